// File: rtl/mem_rw_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_rw_arb_pkg
// Purpose  : Shared types and helpers for the memory read/write arbiter.
//            - state_t    : arbiter FSM states
//            - dir_t      : direction of the most recent burst
//            - beat_cnt_w : width of a counter able to hold 0..max_burst
// Revision : 1.0 - initial release
// ============================================================================
package mem_rw_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    TURN  = 2'd3
  } state_t;

  typedef enum logic {
    DIR_WR = 1'b0,
    DIR_RD = 1'b1
  } dir_t;

  function automatic int beat_cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_rw_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_rw_arbiter_if
// Purpose  : Bundles the write requester, read requester and single-port RAM
//            signals seen by the arbiter.
//            slave  : arbiter view (requests and mem_rdata in; grants,
//                     strobes, read data and busy out)
//            master : environment view (requesters + RAM)
// Revision : 1.0 - initial release
// ============================================================================
interface mem_rw_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  // Write requester
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_gnt;
  // Read requester
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  // Memory side
  logic          mem_wr;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  // Status
  logic          busy;

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_rdata,
    output wr_gnt, rd_gnt, rd_valid, rd_data,
           mem_wr, mem_rd, mem_addr, mem_wdata, busy
  );

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_rdata,
    input  wr_gnt, rd_gnt, rd_valid, rd_data,
           mem_wr, mem_rd, mem_addr, mem_wdata, busy
  );

endinterface
`default_nettype wire

// File: rtl/mem_rw_turn_timer.sv
`default_nettype none
// ============================================================================
// Module   : mem_rw_turn_timer
// Purpose  : Loadable down-counter timing the bus turnaround gap. A load
//            starts the gap; o_done is high during the last gap cycle, so a
//            gap lasts exactly TURN_CYC cycles.
// Ports    : clk, rst  - clock / synchronous active-high reset
//            i_load    - start a new gap (next cycle is the first gap cycle)
//            o_done    - current cycle is the final gap cycle
// Revision : 1.0 - initial release
// ============================================================================
module mem_rw_turn_timer #(
  parameter int TURN_CYC = 1
) (
  input  wire  clk,
  input  wire  rst,
  input  logic i_load,
  output logic o_done
);

  localparam int CW = $clog2(TURN_CYC + 1);
  localparam logic [CW-1:0] c_LOAD_VAL = CW'(TURN_CYC - 1);

  logic [CW-1:0] r_cnt;
  logic          r_active;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_load) begin
      r_cnt    <= c_LOAD_VAL;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (r_cnt == '0) begin
        r_active <= 1'b0;
      end else begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  assign o_done = r_active && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/mem_rw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_rw_arbiter
// Purpose  : Shares a single-port RAM between a write and a read requester.
//            Strobes never overlap, every burst is followed by a TURN_CYC
//            idle gap, bursts are capped at MAX_BURST beats when the other
//            side is waiting, and ties alternate direction.
// Ports    : clk, rst       - clock / synchronous active-high reset
//            bus (slave)    - wr_req/wr_addr/wr_data/wr_gnt,
//                             rd_req/rd_addr/rd_gnt/rd_valid/rd_data,
//                             mem_wr/mem_rd/mem_addr/mem_wdata/mem_rdata,
//                             busy
// Revision : 1.0 - initial release
// ============================================================================
module mem_rw_arbiter
  import mem_rw_arb_pkg::*;
#(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4,
  parameter int TURN_CYC  = 1
) (
  input  wire               clk,
  input  wire               rst,
  mem_rw_arbiter_if.slave   bus
);

  localparam int BW = beat_cnt_w(MAX_BURST);
  localparam logic [BW-1:0] c_LAST_BEAT = BW'(MAX_BURST - 1);

  state_t        r_state;
  dir_t          r_last_dir;
  logic [BW-1:0] r_beat_cnt;
  logic          r_rd_valid;

  logic          w_wr_beat;
  logic          w_rd_beat;
  logic          w_wr_exit;
  logic          w_rd_exit;
  logic          w_turn_done;
  logic [AW-1:0] w_mem_addr;
  logic [DW-1:0] w_mem_wdata;

  // A beat happens whenever the active direction's requester is asking.
  assign w_wr_beat = (r_state == WRITE) && bus.wr_req;
  assign w_rd_beat = (r_state == READ)  && bus.rd_req;

  // A burst ends when its requester lets go, or when the final allowed beat
  // is taken while the opposite requester is waiting.
  assign w_wr_exit = (r_state == WRITE) &&
                     (!bus.wr_req || ((r_beat_cnt == c_LAST_BEAT) && bus.rd_req));
  assign w_rd_exit = (r_state == READ) &&
                     (!bus.rd_req || ((r_beat_cnt == c_LAST_BEAT) && bus.wr_req));

  mem_rw_turn_timer #(
    .TURN_CYC (TURN_CYC)
  ) u_turn_timer (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_wr_exit || w_rd_exit),
    .o_done (w_turn_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_last_dir <= DIR_RD;
      r_beat_cnt <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_beat;
      case (r_state)
        IDLE: begin
          // On a tie, the side that did not go last wins.
          if (bus.wr_req && (!bus.rd_req || (r_last_dir == DIR_RD))) begin
            r_state <= WRITE;
          end else if (bus.rd_req) begin
            r_state <= READ;
          end
        end
        WRITE: begin
          if (w_wr_exit) begin
            r_state    <= TURN;
            r_last_dir <= DIR_WR;
            r_beat_cnt <= '0;
          end else if (r_beat_cnt == c_LAST_BEAT) begin
            r_beat_cnt <= '0;  // unopposed: keep streaming
          end else begin
            r_beat_cnt <= r_beat_cnt + BW'(1);
          end
        end
        READ: begin
          if (w_rd_exit) begin
            r_state    <= TURN;
            r_last_dir <= DIR_RD;
            r_beat_cnt <= '0;
          end else if (r_beat_cnt == c_LAST_BEAT) begin
            r_beat_cnt <= '0;
          end else begin
            r_beat_cnt <= r_beat_cnt + BW'(1);
          end
        end
        TURN: begin
          r_beat_cnt <= '0;
          if (w_turn_done) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    if (r_state == WRITE) begin
      w_mem_addr  = bus.wr_addr;
      w_mem_wdata = bus.wr_data;
    end else if (r_state == READ) begin
      w_mem_addr  = bus.rd_addr;
    end
  end

  assign bus.wr_gnt    = w_wr_beat;
  assign bus.mem_wr    = w_wr_beat;
  assign bus.rd_gnt    = w_rd_beat;
  assign bus.mem_rd    = w_rd_beat;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_data   = bus.mem_rdata;
  assign bus.busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_rw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_rw_arbiter
// Purpose  : Self-checking bench for mem_rw_arbiter: per-cycle vector table,
//            contention / unopposed-burst sequences, a read-data scoreboard,
//            and overlap / turnaround-gap monitors. Includes a small RAM with
//            1-cycle read latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_rw_arbiter;

  localparam int AW        = 8;
  localparam int DW        = 8;
  localparam int MAX_BURST = 4;
  localparam int TURN_CYC  = 1;
  localparam int NV        = 24;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;
  int   cyc;
  int   last_wr_cyc;
  int   last_rd_cyc;

  logic [7:0] ram    [int];
  logic [7:0] shadow [int];
  logic [7:0] sb_q   [$];

  mem_rw_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_rw_arbiter #(
    .AW        (AW),
    .DW        (DW),
    .MAX_BURST (MAX_BURST),
    .TURN_CYC  (TURN_CYC)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ram_rd(input int a);
    if (ram.exists(a)) return ram[a];
    return 8'h00;
  endfunction

  function automatic logic [7:0] shadow_rd(input int a);
    if (shadow.exists(a)) return shadow[a];
    return 8'h00;
  endfunction

  // RAM: read sees pre-write contents, data returned one cycle later.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_rd) bus.mem_rdata <= ram_rd(int'(bus.mem_addr));
    if (bus.mem_wr) ram[int'(bus.mem_addr)] = bus.mem_wdata;
  end

  // Scoreboard and protocol monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.rd_valid) begin
      if (sb_q.size() == 0) begin
        chk("rd_valid_without_gnt", 1, 0);
      end else begin
        chk("rd_data", int'(bus.rd_data), int'(sb_q.pop_front()));
      end
    end
    if (!rst && bus.wr_gnt) shadow[int'(bus.wr_addr)] = bus.wr_data;
    if (!rst && bus.rd_gnt) sb_q.push_back(shadow_rd(int'(bus.rd_addr)));
    if (bus.mem_wr || bus.mem_rd)
      chk("no_overlap", int'(bus.mem_wr && bus.mem_rd), 0);
    if (bus.mem_wr) begin
      chk("wr_after_rd_gap", int'((cyc - last_rd_cyc) > TURN_CYC + 1), 1);
      last_wr_cyc = cyc;
    end
    if (bus.mem_rd) begin
      chk("rd_after_wr_gap", int'((cyc - last_wr_cyc) > TURN_CYC + 1), 1);
      last_rd_cyc = cyc;
    end
  end

  typedef struct packed {
    logic       rst;
    logic       wq;
    logic       rq;
    logic [7:0] wa;
    logic [7:0] wd;
    logic [7:0] ra;
    logic       ewr;
    logic       erd;
    logic       ebusy;
    logic       evld;
    logic [7:0] eaddr;
    logic [7:0] ewd;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input int r, input int wq, input int rq,
                              input int wa, input int wd, input int ra,
                              input int ewr, input int erd, input int eb,
                              input int ev, input int ea, input int ewd);
    vec_t v;
    v.rst = r[0];    v.wq = wq[0];   v.rq = rq[0];
    v.wa  = wa[7:0]; v.wd = wd[7:0]; v.ra = ra[7:0];
    v.ewr = ewr[0];  v.erd = erd[0]; v.ebusy = eb[0]; v.evld = ev[0];
    v.eaddr = ea[7:0]; v.ewd = ewd[7:0];
    return v;
  endfunction

  initial begin
    logic g_w;
    logic g_r;
    int   p;
    int   ew;
    int   er;

    n_chk = 0; n_err = 0; cyc = 0;
    last_wr_cyc = -100; last_rd_cyc = -100;
    rst = 1'b1;
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;

    //             rst wq rq  wa     wd     ra     ewr erd bsy vld eaddr  ewdata
    vecs[0]  = mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00);
    vecs[1]  = mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00);
    vecs[2]  = mk(0, 1, 0, 8'h10, 8'hA5, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00);
    vecs[3]  = mk(0, 1, 0, 8'h10, 8'hA5, 8'h00, 1, 0, 1, 0, 8'h10, 8'hA5);
    vecs[4]  = mk(0, 0, 1, 8'h10, 8'hA5, 8'h10, 0, 0, 1, 0, 8'h10, 8'hA5);
    vecs[5]  = mk(0, 0, 1, 8'h10, 8'hA5, 8'h10, 0, 0, 1, 0, 8'h00, 8'h00);
    vecs[6]  = mk(0, 0, 1, 8'h10, 8'hA5, 8'h10, 0, 0, 0, 0, 8'h00, 8'h00);
    vecs[7]  = mk(0, 0, 1, 8'h10, 8'hA5, 8'h10, 0, 1, 1, 0, 8'h10, 8'h00);
    vecs[8]  = mk(0, 0, 0, 8'h10, 8'hA5, 8'h10, 0, 0, 1, 1, 8'h10, 8'h00);
    vecs[9]  = mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0, 8'h00, 8'h00);
    vecs[10] = mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00);
    // tie after a read burst: write wins
    vecs[11] = mk(0, 1, 1, 8'h20, 8'h3C, 8'h20, 0, 0, 0, 0, 8'h00, 8'h00);
    vecs[12] = mk(0, 1, 1, 8'h20, 8'h3C, 8'h20, 1, 0, 1, 0, 8'h20, 8'h3C);
    vecs[13] = mk(0, 0, 0, 8'h20, 8'h3C, 8'h20, 0, 0, 1, 0, 8'h20, 8'h3C);
    vecs[14] = mk(0, 0, 0, 8'h20, 8'h3C, 8'h20, 0, 0, 1, 0, 8'h00, 8'h00);
    // tie after a write burst: read wins
    vecs[15] = mk(0, 1, 1, 8'h20, 8'h3C, 8'h20, 0, 0, 0, 0, 8'h00, 8'h00);
    vecs[16] = mk(0, 1, 1, 8'h20, 8'h3C, 8'h20, 0, 1, 1, 0, 8'h20, 8'h00);
    vecs[17] = mk(0, 0, 0, 8'h20, 8'h3C, 8'h20, 0, 0, 1, 1, 8'h20, 8'h00);
    vecs[18] = mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0, 8'h00, 8'h00);
    vecs[19] = mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00);
    // reset sampled at the end of the rd_gnt cycle
    vecs[20] = mk(0, 0, 1, 8'h00, 8'h00, 8'h10, 0, 0, 0, 0, 8'h00, 8'h00);
    vecs[21] = mk(1, 0, 1, 8'h00, 8'h00, 8'h10, 0, 1, 1, 0, 8'h10, 8'h00);
    vecs[22] = mk(0, 0, 0, 8'h00, 8'h00, 8'h10, 0, 0, 0, 0, 8'h00, 8'h00);
    vecs[23] = mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00);

    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      rst         = vecs[i].rst;
      bus.wr_req  = vecs[i].wq;
      bus.rd_req  = vecs[i].rq;
      bus.wr_addr = vecs[i].wa;
      bus.wr_data = vecs[i].wd;
      bus.rd_addr = vecs[i].ra;
      @(negedge clk);
      chk($sformatf("v%0d mem_wr", i),    int'(bus.mem_wr),    int'(vecs[i].ewr));
      chk($sformatf("v%0d wr_gnt", i),    int'(bus.wr_gnt),    int'(vecs[i].ewr));
      chk($sformatf("v%0d mem_rd", i),    int'(bus.mem_rd),    int'(vecs[i].erd));
      chk($sformatf("v%0d rd_gnt", i),    int'(bus.rd_gnt),    int'(vecs[i].erd));
      chk($sformatf("v%0d busy", i),      int'(bus.busy),      int'(vecs[i].ebusy));
      chk($sformatf("v%0d rd_valid", i),  int'(bus.rd_valid),  int'(vecs[i].evld));
      chk($sformatf("v%0d mem_addr", i),  int'(bus.mem_addr),  int'(vecs[i].eaddr));
      chk($sformatf("v%0d mem_wdata", i), int'(bus.mem_wdata), int'(vecs[i].ewd));
      @(posedge clk);
      #1;
    end

    // Contention: both requesters held from reset release.
    rst = 1'b1;
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.wr_req = 1'b1; bus.rd_req = 1'b1;
    bus.wr_addr = 8'h40; bus.wr_data = 8'h40 ^ 8'h5A; bus.rd_addr = 8'h40;
    for (int k = 0; k < 26; k++) begin
      @(negedge clk);
      ew = 0; er = 0;
      if (k > 0) begin
        p  = (k - 1) % 12;
        ew = (p < 4) ? 1 : 0;
        er = (p >= 6 && p < 10) ? 1 : 0;
      end
      chk($sformatf("cont%0d mem_wr", k), int'(bus.mem_wr), ew);
      chk($sformatf("cont%0d mem_rd", k), int'(bus.mem_rd), er);
      g_w = bus.wr_gnt;
      g_r = bus.rd_gnt;
      @(posedge clk);
      #1;
      if (g_w) begin
        bus.wr_addr = bus.wr_addr + 8'h01;
        bus.wr_data = bus.wr_addr ^ 8'h5A;
      end
      if (g_r) bus.rd_addr = bus.rd_addr + 8'h01;
    end
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("cont_settle busy", int'(bus.busy), 0);
    @(posedge clk);
    #1;

    // Unopposed write burst: 10 back-to-back beats across counter wraps.
    bus.wr_addr = 8'h80; bus.wr_data = 8'h80 ^ 8'h5A;
    for (int j = 0; j < 14; j++) begin
      bus.wr_req = (j <= 10);
      @(negedge clk);
      chk($sformatf("burst%0d wr_gnt", j), int'(bus.wr_gnt), (j >= 1 && j <= 10) ? 1 : 0);
      if (j == 13) chk("burst_end busy", int'(bus.busy), 0);
      g_w = bus.wr_gnt;
      @(posedge clk);
      #1;
      if (g_w) begin
        bus.wr_addr = bus.wr_addr + 8'h01;
        bus.wr_data = bus.wr_addr ^ 8'h5A;
      end
    end

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
